// File: rtl/router_pkg.sv
// Shared router types and constants: port enumeration, allocator FSM states,
// and the round-robin pointer helper used by outport_allocator.
package router_pkg;

   localparam int NUM_OF_PORTS = 5;
   localparam int CNT_W        = 16;
   localparam int PTR_W        = $clog2(NUM_OF_PORTS);

   typedef enum logic [PTR_W-1:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } PORT_T;

   typedef enum logic {
      A_IDLE,
      A_LOCKED
   } ALLOC_STATE_T;

   // Pointer successor modulo NUM_OF_PORTS; the ports are not a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_OF_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/outport_allocator_if.sv
// Request/ack bundle between the Switch crossbar (master) and the per-output
// allocator (slave). o_grant_cnt carries data only with OUTPORT_ALLOC_STATS_EN.
interface outport_allocator_if;
   import router_pkg::*;

   logic [NUM_OF_PORTS-1:0] i_outport_req [NUM_OF_PORTS];
   logic [NUM_OF_PORTS-1:0] i_out_ready;
   logic [NUM_OF_PORTS-1:0] i_tail_sent;
   logic [NUM_OF_PORTS-1:0] o_outport_ack [NUM_OF_PORTS];
   logic [NUM_OF_PORTS-1:0] o_out_busy;
   logic [CNT_W-1:0]        o_grant_cnt   [NUM_OF_PORTS];

   modport master (
      output i_outport_req, i_out_ready, i_tail_sent,
      input  o_outport_ack, o_out_busy, o_grant_cnt
   );

   modport slave (
      input  i_outport_req, i_out_ready, i_tail_sent,
      output o_outport_ack, o_out_busy, o_grant_cnt
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr,
// wrapping modulo NUM_OF_PORTS. Reused for output and VC allocation.
module rr_arbiter
   import router_pkg::*;
(
   input  logic [NUM_OF_PORTS-1:0] i_req,
   input  logic [PTR_W-1:0]        i_ptr,
   output logic [NUM_OF_PORTS-1:0] o_grant,
   output logic [PTR_W-1:0]        o_idx,
   output logic                    o_valid
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < NUM_OF_PORTS; k++) begin
         int               j;
         logic [PTR_W-1:0] w_pos;
         j = int'(i_ptr) + k;
         if (j >= NUM_OF_PORTS) j = j - NUM_OF_PORTS;
         w_pos = PTR_W'(j);
         if (!o_valid && i_req[w_pos]) begin
            o_valid        = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

// File: rtl/outport_allocator.sv
// Per-output wormhole switch allocator: each output locks to one input from
// head to tail. Optional grant counters/assertion under OUTPORT_ALLOC_STATS_EN.
module outport_allocator
   import router_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   outport_allocator_if.slave  bus
);

   for (genvar o = 0; o < NUM_OF_PORTS; o++) begin : g_out
      ALLOC_STATE_T            r_state, w_state_nxt;
      logic [PTR_W-1:0]        r_owner, w_owner_nxt;
      logic [PTR_W-1:0]        r_ptr, w_ptr_nxt;
      logic [NUM_OF_PORTS-1:0] r_ack, w_ack_nxt;
      logic [NUM_OF_PORTS-1:0] w_grant;
      logic [PTR_W-1:0]        w_win;
      logic                    w_valid;
      logic                    w_busy;

      rr_arbiter u_arb (
         .i_req   (bus.i_outport_req[o]),
         .i_ptr   (r_ptr),
         .o_grant (w_grant),
         .o_idx   (w_win),
         .o_valid (w_valid)
      );

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_state <= A_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_ack   <= '0;
         end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ack   <= w_ack_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_owner_nxt = r_owner;
         w_ptr_nxt   = r_ptr;
         w_ack_nxt   = r_ack;
         case (r_state)
            A_IDLE: begin
               if (bus.i_out_ready[o] && w_valid) begin
                  w_state_nxt = A_LOCKED;
                  w_owner_nxt = w_win;
                  w_ptr_nxt   = ptr_inc(w_win);
                  w_ack_nxt   = w_grant;
               end else begin
                  w_ack_nxt   = '0;
               end
            end
            A_LOCKED: begin
               // Release wins over any pending request; arbitration resumes from A_IDLE.
               if (bus.i_tail_sent[o] || !bus.i_outport_req[o][r_owner]) begin
                  w_state_nxt = A_IDLE;
                  w_ack_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = A_IDLE;
               w_ack_nxt   = '0;
            end
         endcase
      end

      always_comb begin
         w_busy = (r_state == A_LOCKED);
      end

      assign bus.o_outport_ack[o] = r_ack;
      assign bus.o_out_busy[o]    = w_busy;

`ifdef OUTPORT_ALLOC_STATS_EN
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_cnt <= '0;
         end else if (r_state == A_IDLE && w_state_nxt == A_LOCKED && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign bus.o_grant_cnt[o] = r_cnt;

      a_ack_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_ack));
`else
      assign bus.o_grant_cnt[o] = '0;
`endif
   end

endmodule

// File: tb/tb_outport_allocator.sv
// Directed self-checking bench for outport_allocator; grant-counter checks
// are compiled in only with OUTPORT_ALLOC_STATS_EN.
module tb_outport_allocator;
   import router_pkg::*;

   logic i_clk;
   logic i_rst_n;
   int   n_checks;
   int   n_fail;

   localparam int E = int'(EAST);
   localparam int N = int'(NORTH);

   outport_allocator_if bus ();

   outport_allocator dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int o = 0; o < NUM_OF_PORTS; o++) begin
         bus.i_outport_req[o] = '0;
      end
      bus.i_out_ready = '0;
      bus.i_tail_sent = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      i_rst_n  = 1'b0;
      clear_inputs();
      #12;
      for (int o = 0; o < NUM_OF_PORTS; o++) begin
         check($sformatf("rst_ack_%0d", o), 32'(bus.o_outport_ack[o]), 32'h0);
         check($sformatf("rst_cnt_%0d", o), 32'(bus.o_grant_cnt[o]), 32'h0);
      end
      check("rst_busy", 32'(bus.o_out_busy), 32'h0);
      i_rst_n = 1'b1;
      step();

      // Single request from input 0 on EAST.
      bus.i_out_ready[E]   = 1'b1;
      bus.i_outport_req[E] = 5'b00001;
      step();
      check("east_in0_ack", 32'(bus.o_outport_ack[E]), 32'h01);
      check("east_in0_busy", 32'(bus.o_out_busy), 32'h04);
      bus.i_tail_sent[E] = 1'b1;
      step();
      check("east_in0_tail", 32'(bus.o_outport_ack[E]), 32'h00);

      // rr_ptr is 1: input 1 wins, then the request is withdrawn.
      bus.i_tail_sent[E]   = 1'b0;
      bus.i_outport_req[E] = 5'b00010;
      step();
      check("east_in1_ack", 32'(bus.o_outport_ack[E]), 32'h02);
      bus.i_outport_req[E] = 5'b00000;
      step();
      check("east_withdraw_ack", 32'(bus.o_outport_ack[E]), 32'h00);
      check("east_withdraw_busy", 32'(bus.o_out_busy), 32'h00);

      // rr_ptr is 2 with inputs 1,3,4 requesting: input 3 holds for 4 flits.
      bus.i_outport_req[E] = 5'b11010;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) ; else ;
         step();
         check($sformatf("east_in3_flit%0d", k), 32'(bus.o_outport_ack[E]), 32'h08);
      end
      bus.i_tail_sent[E]   = 1'b1;
      bus.i_outport_req[E] = 5'b10010;
      step();
      check("east_in3_release", 32'(bus.o_outport_ack[E]), 32'h00);
      bus.i_tail_sent[E] = 1'b0;
      step();
      check("east_in4_ack", 32'(bus.o_outport_ack[E]), 32'h10);

      // Single-flit packet for input 4, then wrap to input 1.
      bus.i_tail_sent[E]   = 1'b1;
      bus.i_outport_req[E] = 5'b00010;
      step();
      check("east_single_flit", 32'(bus.o_outport_ack[E]), 32'h00);
      bus.i_tail_sent[E] = 1'b0;
      step();
      check("east_in1_wrap", 32'(bus.o_outport_ack[E]), 32'h02);
      bus.i_tail_sent[E]   = 1'b1;
      bus.i_outport_req[E] = 5'b00000;
      step();
      check("east_in1_release", 32'(bus.o_outport_ack[E]), 32'h00);
      bus.i_tail_sent[E] = 1'b0;

      // NORTH not ready for 10 cycles; pointer must still be 0 afterwards.
      bus.i_outport_req[N] = 5'b00101;
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("north_stall_%0d", k), 32'(bus.o_outport_ack[N]), 32'h00);
      end
      bus.i_out_ready[N] = 1'b1;
      step();
      check("north_ready_ack", 32'(bus.o_outport_ack[N]), 32'h01);
      check("north_ready_busy", 32'(bus.o_out_busy), 32'h02);

      // Asynchronous reset in the middle of the NORTH packet.
      #3;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_ack", 32'(bus.o_outport_ack[N]), 32'h00);
      check("async_rst_busy", 32'(bus.o_out_busy), 32'h00);
      check("async_rst_cnt_e", 32'(bus.o_grant_cnt[E]), 32'h0);
      #2;
      i_rst_n = 1'b1;
      step();
      check("north_post_rst", 32'(bus.o_outport_ack[N]), 32'h01);

      // Two more NORTH packets: inputs 2 then 0 by round robin.
      bus.i_tail_sent[N] = 1'b1;
      step();
      bus.i_tail_sent[N] = 1'b0;
      step();
      check("north_pkt2", 32'(bus.o_outport_ack[N]), 32'h04);
      bus.i_tail_sent[N] = 1'b1;
      step();
      bus.i_tail_sent[N] = 1'b0;
      step();
      check("north_pkt3", 32'(bus.o_outport_ack[N]), 32'h01);
`ifdef OUTPORT_ALLOC_STATS_EN
      check("cnt_north_3", 32'(bus.o_grant_cnt[N]), 32'd3);
      check("cnt_east_0", 32'(bus.o_grant_cnt[E]), 32'd0);
`else
      check("cnt_tied_0", 32'(bus.o_grant_cnt[N]), 32'd0);
`endif

      clear_inputs();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
